// File: rtl/n2one_if.sv
// n2one_if: merged-stream bundle for n2one.
// Producers and downstream pause on one side, merged beat on the other.
interface n2one_if #(
  parameter int WIDTH = 40,
  parameter int NCH   = 4
);
  localparam int DCW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 pause;
  logic [NCH-1:0]       vdin;
  logic [NCH*WIDTH-1:0] din;
  logic [WIDTH-1:0]     dout;
  logic                 vdout;
  logic [DCW-1:0]       dchan;
  logic [NCH-1:0]       pnc;
  logic                 ovf;

  modport master (
    output pause, vdin, din,
    input  dout, vdout, dchan, pnc, ovf
  );

  modport slave (
    input  pause, vdin, din,
    output dout, vdout, dchan, pnc, ovf
  );
endinterface

// File: rtl/n2one.sv
// n2one: per-channel FIFOs drained onto one registered stream by a
// round-robin or fixed-priority arbiter, with registered pnc backpressure.
module n2one #(
  parameter int WIDTH = 40,
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  parameter int PRIO  = 0
) (
  input  logic   clk,
  input  logic   reset,
  n2one_if.slave io
);
  localparam int DCW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [NCH][DEPTH];
  logic [PW-1:0]    rp_q  [NCH];
  logic [PW-1:0]    rp_d  [NCH];
  logic [PW-1:0]    wp_q  [NCH];
  logic [PW-1:0]    wp_d  [NCH];
  logic [CW-1:0]    cnt_q [NCH];
  logic [CW-1:0]    cnt_d [NCH];

  logic [NCH-1:0]   cand, pop, push;
  logic [NCH-1:0]   pnc_q, pnc_d;
  logic [DCW-1:0]   last_q, last_d;
  logic [DCW-1:0]   dchan_q, dchan_d;
  logic [DCW-1:0]   win, ix;
  logic [WIDTH-1:0] dout_q, dout_d, head;
  logic             vdout_q, vdout_d;
  logic             ovf_q, ovf_d;
  logic             any;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // only registered occupancy is eligible
  always_comb begin
    for (int i = 0; i < NCH; i++)
      cand[i] = (cnt_q[i] != '0);
  end

  always_comb begin
    any = 1'b0;
    win = '0;
    ix  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (PRIO == 0)
        ix = DCW'((int'(last_q) + 1 + k) % NCH);
      else
        ix = DCW'(k);
      if (!any && cand[ix]) begin
        any = 1'b1;
        win = ix;
      end
    end
  end

  assign head = mem_q[win][rp_q[win]];

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NCH; i++) begin
      pop[i]  = !io.pause && any
              && (win == DCW'(i));
      // full channel still accepts when popped
      push[i] = io.vdin[i]
              && ((cnt_q[i] != CW'(DEPTH)) || pop[i]);
      if (io.vdin[i] && !push[i])
        ovf_d = 1'b1;
      cnt_d[i] = cnt_q[i] + CW'(push[i])
               - CW'(pop[i]);
      pnc_d[i] = (cnt_d[i] >= CW'(DEPTH - 1));
      rp_d[i]  = pop[i]  ? nxt(rp_q[i]) : rp_q[i];
      wp_d[i]  = push[i] ? nxt(wp_q[i]) : wp_q[i];
    end
  end

  always_comb begin
    dout_d  = dout_q;
    dchan_d = dchan_q;
    vdout_d = vdout_q;
    last_d  = last_q;
    if (!io.pause) begin
      vdout_d = any;
      if (any) begin
        dout_d  = head;
        dchan_d = win;
        if (PRIO == 0)
          last_d = win;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (push[i])
        mem_q[i][wp_q[i]] <= io.din[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        rp_q[i]  <= '0;
        wp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      pnc_q   <= '0;
      last_q  <= DCW'(NCH - 1);
      dchan_q <= '0;
      dout_q  <= '0;
      vdout_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      pnc_q   <= pnc_d;
      last_q  <= last_d;
      dchan_q <= dchan_d;
      dout_q  <= dout_d;
      vdout_q <= vdout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.dout  = dout_q;
  assign io.vdout = vdout_q;
  assign io.dchan = dchan_q;
  assign io.pnc   = pnc_q;
  assign io.ovf   = ovf_q;
endmodule

// File: tb/tb_n2one.sv
// tb_n2one: round-robin and fixed-priority n2one instances driven
// with identical directed stimulus; delivered beats checked from queues.
module tb_n2one;
  localparam int W = 40;
  localparam int N = 4;
  localparam int D = 2;

  typedef logic [41:0] exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  n2one_if #(.WIDTH(W), .NCH(N)) f0 ();
  n2one_if #(.WIDTH(W), .NCH(N)) f1 ();

  n2one #(
    .WIDTH(W), .NCH(N), .DEPTH(D), .PRIO(0)
  ) u_rr (
    .clk(clk), .reset(rst), .io(f0.slave)
  );

  n2one #(
    .WIDTH(W), .NCH(N), .DEPTH(D), .PRIO(1)
  ) u_fp (
    .clk(clk), .reset(rst), .io(f1.slave)
  );

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(
    input logic p,
    input logic [3:0] v,
    input logic [159:0] d
  );
    f0.pause = p; f0.vdin = v; f0.din = d;
    f1.pause = p; f1.vdin = v; f1.din = d;
  endtask

  function automatic logic [159:0] sl(
    input int ch,
    input logic [39:0] val
  );
    logic [159:0] r;
    r = '0;
    r[ch*40 +: 40] = val;
    return r;
  endfunction

  task automatic exp2(input int ch, input logic [39:0] v);
    q0.push_back({2'(ch), v});
    q1.push_back({2'(ch), v});
  endtask

  task automatic chk2(
    input string nm,
    input logic [63:0] a0,
    input logic [63:0] a1,
    input logic [63:0] req
  );
    chk({nm, "_rr"}, a0, req);
    chk({nm, "_fp"}, a1, req);
  endtask

  task automatic qempty(input string nm);
    chk({nm, "_qrr"}, 64'(q0.size()), 0);
    chk({nm, "_qfp"}, 64'(q1.size()), 0);
  endtask

  task automatic do_reset(input string nm);
    qempty(nm);
    rst = 1'b1;
    drv(0, 4'b0, '0);
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (!rst && f0.vdout && !f0.pause) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_extra act=%0h req=none",
                 {f0.dchan, f0.dout});
      end else
        chk("rr_beat", 64'({f0.dchan, f0.dout}),
            64'(q0.pop_front()));
    end
    if (!rst && f1.vdout && !f1.pause) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL fp_extra act=%0h req=none",
                 {f1.dchan, f1.dout});
      end else
        chk("fp_beat", 64'({f1.dchan, f1.dout}),
            64'(q1.pop_front()));
    end
  end

  initial begin
    drv(0, 4'b0, '0);
    step();
    step();
    rst = 1'b0;
    step();

    chk2("rst_vdout", f0.vdout, f1.vdout, 0);
    chk2("rst_dout", f0.dout, f1.dout, 0);
    chk2("rst_dchan", f0.dchan, f1.dchan, 0);
    chk2("rst_pnc", f0.pnc, f1.pnc, 0);
    chk2("rst_ovf", f0.ovf, f1.ovf, 0);

    // single beat, two-cycle latency
    drv(0, 4'b0100, sl(2, 40'h12345));
    exp2(2, 40'h12345);
    step();
    drv(0, 4'b0, '0);
    chk2("sb_t1", f0.vdout, f1.vdout, 0);
    step();
    chk2("sb_vd", f0.vdout, f1.vdout, 1);
    chk2("sb_dout", f0.dout, f1.dout, 40'h12345);
    chk2("sb_dch", f0.dchan, f1.dchan, 2);
    step();
    chk2("sb_t3", f0.vdout, f1.vdout, 0);

    // preload two beats per channel under pause
    do_reset("pre");
    drv(1, 4'hF, {40'hA000000003, 40'hA000000002,
                  40'hA000000001, 40'hA000000000});
    step();
    chk2("pl_pnc1", f0.pnc, f1.pnc, 4'hF);
    drv(1, 4'hF, {40'hB000000003, 40'hB000000002,
                  40'hB000000001, 40'hB000000000});
    step();
    drv(1, 4'b0, '0);
    for (int i = 0; i < N; i++)
      q0.push_back({2'(i), 40'hA000000000 + 40'(i)});
    for (int i = 0; i < N; i++)
      q0.push_back({2'(i), 40'hB000000000 + 40'(i)});
    for (int i = 0; i < N; i++) begin
      q1.push_back({2'(i), 40'hA000000000 + 40'(i)});
      q1.push_back({2'(i), 40'hB000000000 + 40'(i)});
    end
    step();
    chk2("pl_pnc2", f0.pnc, f1.pnc, 4'hF);
    chk2("pl_vd", f0.vdout, f1.vdout, 0);
    drv(0, 4'b0, '0);
    repeat (10) step();
    chk2("pl_end", f0.vdout, f1.vdout, 0);

    // pause freezes output; grace push accepted
    do_reset("arb");
    drv(0, 4'b1000, sl(3, 40'h33));
    exp2(3, 40'h33);
    step();
    drv(0, 4'b0, '0);
    step();
    drv(1, 4'b0010, sl(1, 40'h11));
    exp2(1, 40'h11);
    chk2("bp_vd", f0.vdout, f1.vdout, 1);
    chk2("bp_dout", f0.dout, f1.dout, 40'h33);
    step();
    drv(1, 4'b0010, sl(1, 40'h22));
    exp2(1, 40'h22);
    chk2("bp_pnc", f0.pnc, f1.pnc, 4'b0010);
    step();
    drv(1, 4'b0, '0);
    repeat (3) begin
      chk2("bp_hpnc", f0.pnc, f1.pnc, 4'b0010);
      chk2("bp_hvd", f0.vdout, f1.vdout, 1);
      chk2("bp_hdout", f0.dout, f1.dout, 40'h33);
      chk2("bp_hdch", f0.dchan, f1.dchan, 3);
      step();
    end
    drv(0, 4'b0, '0);
    repeat (6) step();
    chk2("bp_ovf", f0.ovf, f1.ovf, 0);
    chk2("bp_end", f0.vdout, f1.vdout, 0);

    // third push while full is dropped
    do_reset("bp");
    drv(1, 4'b0001, sl(0, 40'hA1));
    exp2(0, 40'hA1);
    step();
    drv(1, 4'b0001, sl(0, 40'hA2));
    exp2(0, 40'hA2);
    step();
    drv(1, 4'b0001, sl(0, 40'hA3));
    chk2("of_pre", f0.ovf, f1.ovf, 0);
    step();
    drv(1, 4'b0, '0);
    chk2("of_set", f0.ovf, f1.ovf, 1);
    step();
    step();
    chk2("of_hold", f0.ovf, f1.ovf, 1);
    drv(0, 4'b0, '0);
    repeat (6) step();
    chk2("of_stick", f0.ovf, f1.ovf, 1);
    qempty("of");

    // asynchronous reset with beats in flight
    drv(0, 4'b0111, sl(0, 40'hC0) | sl(1, 40'hC1)
                    | sl(2, 40'hC2));
    step();
    drv(0, 4'b0, '0);
    step();
    drv(1, 4'b0, '0);
    chk2("ar_vd", f0.vdout, f1.vdout, 1);
    chk2("ar_ovf", f0.ovf, f1.ovf, 1);
    chk2("ar_pnc", |f0.pnc, |f1.pnc, 1);
    #2 rst = 1'b1;
    #1;
    chk2("ar_rvd", f0.vdout, f1.vdout, 0);
    chk2("ar_rpnc", f0.pnc, f1.pnc, 0);
    chk2("ar_rovf", f0.ovf, f1.ovf, 0);
    step();
    rst = 1'b0;
    drv(0, 4'b0, '0);
    repeat (5) begin
      step();
      chk2("ar_idle", f0.vdout, f1.vdout, 0);
    end
    qempty("ar");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/n2one.md
# n2one

Parametrised N-into-one stream merger for the core's writeback/response paths. Each of NCH producers pushes WIDTH-bit beats qualified by a valid bit into its own DEPTH-entry FIFO. A registered arbiter drains the FIFOs onto a single output stream, using either round-robin or fixed-priority order. Per-channel registered pause-next-cycle (pnc) outputs provide backpressure, and a shared downstream `pause` stalls the output.

## Interface
- WIDTH, 40: beat width in bits.
- NCH, 4: number of input channels, ≥2.
- DEPTH, 2: entries per channel FIFO, ≥2, any integer, not required to be a power of two.
- PRIO, 0: arbitration mode. 0 = round-robin, 1 = fixed priority with channel 0 highest.
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pause  in  1  downstream stall; holds the output register and stops FIFO pops.
- vdin  in  NCH  per-channel valid; bit i qualifies slice i of din.
- din  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- dout  out  WIDTH  merged beat (registered).
- vdout  out  1  dout valid (registered).
- dchan  out  max(1,$clog2(NCH))  index of the channel that sourced dout (registered).
- pnc  out  NCH  per-channel pause-next-cycle (registered).
- ovf  out  1  sticky overflow flag; cleared only by reset.

## Operation
- Each channel has a circular FIFO with read pointer, write pointer and occupancy count cnt[i] in 0..DEPTH. Pointers wrap from DEPTH-1 to 0.
- Push: vdin[i]=1 writes din slice i at the write pointer. cnt[i] increments unless the channel is popped in the same cycle.
- Push protocol:
  - Upstream may assert vdin[i] in cycle t only if pnc[i] was 0 in cycle t-1.
  - This gives exactly one grace beat after pnc rises.
- pnc[i] is a register: pnc[i] <= (cnt_next[i] ≥ DEPTH-1).
- Overflow: a push when cnt[i]==DEPTH with no same-cycle pop of channel i drops the beat. The FIFO is unchanged and ovf <= 1.
- Arbitration happens in cycles with pause=0.
  - Candidates are channels with cnt[i]>0. Only registered occupancy counts; a beat pushed this cycle is not eligible.
  - PRIO=0: winner is the first candidate scanning from (last+1) mod NCH upward with wrap. last <= winner on every grant.
  - PRIO=1: winner is the lowest-index candidate; last is unused.
- Grant: the FIFO head is popped. dout <= head, dchan <= winner, vdout <= 1.
- pause=0 with no candidate: vdout <= 0; dout and dchan hold their previous values.
- pause=1: dout, vdout and dchan hold; no pop; last holds. Pushes and pnc updates continue.
- Beat transfer: a beat is delivered downstream in a cycle where vdout=1 and pause=0. Each beat appears exactly once, in per-channel FIFO order.
- Simultaneous push and pop on a channel with cnt==DEPTH is legal: no overflow, cnt unchanged.

## Timing
- Reset values:
  - All cnt and pointers 0; pnc=0; vdout=0; dout=0; dchan=0; ovf=0.
  - last=NCH-1, so channel 0 wins first in round-robin mode.
- Reset is asynchronous. Asserting it mid-operation discards all FIFO contents and any pending output beat at once.
- Latency: vdin[i] in cycle t, with an empty FIFO, no contention and no pause → vdout=1 with that beat in cycle t+2.
- Throughput: one beat per cycle when unpaused and any FIFO is non-empty.
- Backpressure latency: pnc[i] rises the cycle after cnt_next reaches DEPTH-1. It falls the cycle after cnt_next drops below DEPTH-1.
- Fairness (PRIO=0): with all NCH FIFOs continuously non-empty, each channel wins exactly once every NCH grants.

## Test plan
- Single beat: NCH=4, vdin=4'b0100, din slice 2=40'h12345 at cycle 5 → vdout=1, dout=40'h12345, dchan=2 at cycle 7; vdout=0 at cycle 8.
- Round-robin: PRIO=0, all four channels preloaded with 2 beats, pause=0 → dchan sequence 0,1,2,3,0,1,2,3, then vdout=0.
- Fixed priority: PRIO=1, same preload → dchan sequence 0,0,1,1,2,2,3,3.
- Pause and backpressure: DEPTH=2, pause=1 held, channel 1 pushes every cycle that the protocol allows →
  - pnc[1]=1 from the cycle after the first push;
  - the second (grace) push is accepted and cnt=2;
  - dout, vdout and dchan are frozen;
  - after pause=0 both beats are delivered in order and ovf stays 0.
- Overflow: DEPTH=2, pause=1, a third push on channel 0 while pnc[0]=1 → ovf=1 from the next cycle and stays 1. After unpause exactly 2 beats drain.
- Async reset mid-stream: assert reset between clock edges while 3 channels hold beats → vdout, pnc and ovf go to 0 immediately. After release with no pushes, vdout stays 0.
